// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: hex segment table, blank codes, digit index type.
// Combinational only; no latency, no backpressure.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] ANS_OFF   = 8'hFF;

  typedef logic [2:0] dig_t;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the least significant slice.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Maps one hex nibble to its active-low seven-segment pattern.
// Purely combinational (zero latency); no backpressure.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_seg(nib);

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display driver; tear-free commit at frame boundaries, registered outputs.
// One-cycle output latency; free-running, no backpressure. SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int DIGITS  = 8
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic [31:0]       value,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] ans,
  output logic              frame_done
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0]     div_cnt;
  dig_t              dig;
  dig_t              dig_next;
  logic [31:0]       pending;
  logic [31:0]       shown;
  logic [31:0]       shown_next;
  logic              tick;
  logic              frame_wrap;
  logic [3:0]        nib;
  logic [6:0]        dec_seg;
  logic              blank;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] ans_next;

  assign tick       = (div_cnt == DW'(CLK_DIV - 1));
  assign dig_next   = tick ? dig + 3'd1 : dig;
  assign frame_wrap = tick && (dig == 3'd7);

  // Outputs are decoded from the post-edge word so digit 0 of a new frame
  // already shows the freshly committed value.
  assign shown_next = frame_wrap ? (load ? value : pending) : shown;
  assign nib        = shown_next[{dig_next, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign blank = (dig_next != 3'd0) && ((shown_next >> {dig_next, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  assign seg_next = blank ? SEG_BLANK : dec_seg;
  assign ans_next = blank ? ANS_OFF : ~(DIGITS'(1) << dig_next);

  always_ff @(posedge hclk) begin
    if (rst) begin
      div_cnt    <= '0;
      dig        <= '0;
      pending    <= '0;
      shown      <= '0;
      seg        <= SEG_BLANK;
      ans        <= ANS_OFF;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + DW'(1);
      dig        <= dig_next;
      if (load)
        pending  <= value;
      shown      <= shown_next;
      seg        <= seg_next;
      ans        <= ans_next;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with CLK_DIV = 4: randomized and directed stimulus against a cycle-count reference model.
module tb_seg7_scan;

  localparam int CD = 4;
  localparam int FR = 8 * CD;

  logic        hclk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] value = 32'd0;
  logic [6:0]  seg;
  logic [7:0]  ans;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: k = edges since reset released, plus the words the display should hold.
  int          k = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_shown = 32'd0;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan #(.CLK_DIV(CD), .DIGITS(8)) dut (
    .hclk       (hclk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .seg        (seg),
    .ans        (ans),
    .frame_done (frame_done)
  );

  always #10 hclk = ~hclk;

  task automatic step(input logic r, input logic ld, input logic [31:0] v);
    @(negedge hclk);
    rst = r;
    load = ld;
    value = v;
    @(posedge hclk);
    if (r) begin
      k = 0;
      m_pend = 32'd0;
      m_shown = 32'd0;
    end else begin
      k++;
      if (ld) m_pend = v;
      if (k % FR == 0) m_shown = m_pend;
    end
    #1;
    load = 1'b0;
  endtask

  function automatic int cur_dig();
    return (k / CD) % 8;
  endfunction

  function automatic bit is_blank(input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    return (d != 0) && ((m_shown >> (4 * d)) == 32'd0);
`else
    return (d < 0);
`endif
  endfunction

  function automatic logic [7:0] exp_ans();
    int d;
    d = cur_dig();
    if (k == 0 || is_blank(d)) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  function automatic logic [6:0] exp_seg();
    int d;
    d = cur_dig();
    if (k == 0 || is_blank(d)) return 7'h7F;
    return segtab[(m_shown >> (4 * d)) & 32'hF];
  endfunction

  function automatic logic exp_fd();
    return (k > 0) && (k % FR == 0);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'd0);
      n_cmp++;
      if (ans !== 8'hFF || seg !== 7'h7F || frame_done !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got ans=%h seg=%h fd=%b want ans=ff seg=7f fd=0", i, ans, seg, frame_done);
      end
    end
    step(1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (ans !== 8'hFE || seg !== 7'h40) begin
      n_bad++;
      $display("FAIL reset_release got ans=%h seg=%h want ans=fe seg=40", ans, seg);
    end
  endtask

  task automatic test_scan();
    int fd_cnt;
    fd_cnt = 0;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 2 * FR + 4; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (frame_done === 1'b1) fd_cnt++;
      n_cmp++;
      if (ans !== exp_ans() || frame_done !== exp_fd()) begin
        n_bad++;
        $display("FAIL scan k=%0d got ans=%h fd=%b want ans=%h fd=%b", k, ans, frame_done, exp_ans(), exp_fd());
      end
    end
    n_cmp++;
    if (fd_cnt != 2) begin
      n_bad++;
      $display("FAIL scan_fd_count got %0d want 2", fd_cnt);
    end
  endtask

  task automatic test_mid_frame_load();
    step(1'b1, 1'b0, 32'd0);
    while (k < 12) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0123_4567);
    while (k < 2 * FR) begin
      step(1'b0, 1'b0, 32'd0);
      n_cmp++;
      if (ans !== exp_ans() || seg !== exp_seg()) begin
        n_bad++;
        $display("FAIL midload k=%0d got ans=%h seg=%h want ans=%h seg=%h", k, ans, seg, exp_ans(), exp_seg());
      end
      if (k == FR - 1 || k == 2 * FR - 4) begin
        n_cmp++;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (seg !== 7'h7F) begin
`else
        if (seg !== 7'h40) begin
`endif
          n_bad++;
          $display("FAIL midload_digit7 k=%0d got seg=%h", k, seg);
        end
      end
      if (k == FR) begin
        n_cmp++;
        if (seg !== 7'h78 || ans !== 8'hFE) begin
          n_bad++;
          $display("FAIL midload_digit0 got ans=%h seg=%h want ans=fe seg=78", ans, seg);
        end
      end
    end
  endtask

  task automatic test_boundary_collision();
    step(1'b1, 1'b0, 32'd0);
    while (k < FR - 1) step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < FR; i++) begin
      n_cmp++;
      if (seg !== 7'h0E || seg !== exp_seg() || ans !== exp_ans()) begin
        n_bad++;
        $display("FAIL collision k=%0d got ans=%h seg=%h want ans=%h seg=0e", k, ans, seg, exp_ans());
      end
      step(1'b0, 1'b0, 32'd0);
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    while (k < 21) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    n_cmp++;
    if (ans !== 8'hFF || seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL midreset got ans=%h seg=%h want ans=ff seg=7f", ans, seg);
    end
    while (k < 2 * FR + 2) begin
      step(1'b0, 1'b0, 32'd0);
      n_cmp++;
      if (ans !== exp_ans() || seg !== exp_seg() || frame_done !== exp_fd()) begin
        n_bad++;
        $display("FAIL midreset_after k=%0d got ans=%h seg=%h want ans=%h seg=%h", k, ans, seg, exp_ans(), exp_seg());
      end
      if (cur_dig() == 0) begin
        n_cmp++;
        if (seg !== 7'h40) begin
          n_bad++;
          $display("FAIL midreset_stale k=%0d got seg=%h want 40", k, seg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic [31:0] v;
    step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      v = $urandom();
      if ($urandom_range(0, 3) == 0) v = v >> (4 * $urandom_range(1, 7));
      step(1'b0, ld, v);
      n_cmp++;
      if (ans !== exp_ans() || seg !== exp_seg() || frame_done !== exp_fd()) begin
        n_bad++;
        $display("FAIL random k=%0d got ans=%h seg=%h fd=%b want ans=%h seg=%h fd=%b",
                 k, ans, seg, frame_done, exp_ans(), exp_seg(), exp_fd());
      end
    end
  endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  task automatic test_blanking();
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_00A5);
    while (k < FR) step(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < FR; i++) begin
      n_cmp++;
      if (cur_dig() == 0 && (ans !== 8'hFE || seg !== 7'h12)) begin
        n_bad++;
        $display("FAIL blank_d0 k=%0d got ans=%h seg=%h want ans=fe seg=12", k, ans, seg);
      end else if (cur_dig() == 1 && (ans !== 8'hFD || seg !== 7'h08)) begin
        n_bad++;
        $display("FAIL blank_d1 k=%0d got ans=%h seg=%h want ans=fd seg=08", k, ans, seg);
      end else if (cur_dig() >= 2 && (ans !== 8'hFF || seg !== 7'h7F)) begin
        n_bad++;
        $display("FAIL blank_hi k=%0d got ans=%h seg=%h want ans=ff seg=7f", k, ans, seg);
      end
      step(1'b0, 1'b0, 32'd0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_mid_frame_load();
    test_boundary_collision();
    test_reset_mid_frame();
    test_random();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    test_blanking();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
